spi_master_param: RTL and testbench

//  Parametrised SPI master: generalises the fixed single-slave sensor master to N slave selects,

---
 rtl/spi_master_param.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_master_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with N active-low selects and all four CPOL/CPHA modes.
// Optional macro AUTO_TRIG_EN adds a free-running trigger every TRIG_DIV cycles, ORed with START.
module spi_master_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned N_SS     = 2,
  parameter int unsigned SS_W     = 1,
  parameter int unsigned TRIG_DIV = 2600000
) (
  input  logic              CLK_26,
  input  logic              RST,
  input  logic              START,
  input  logic [SS_W-1:0]   SS_SEL,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              MISO,
  output logic              SCK,
  output logic              MOSI,
  output logic [N_SS-1:0]   SS,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA
);

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e            state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [SS_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              phase_q, phase_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;

  logic trig;
  logic sel_ok;
  logic div_end;
  logic lead_edge;
  logic trail_edge;

`ifdef AUTO_TRIG_EN
  localparam int unsigned TrigW = (TRIG_DIV > 1) ? $clog2(TRIG_DIV) : 1;
  localparam logic [TrigW-1:0] TrigLast = TrigW'(TRIG_DIV - 1);

  logic [TrigW-1:0] trig_cnt_q, trig_cnt_d;

  always_comb begin
    trig_cnt_d = (trig_cnt_q == TrigLast) ? '0 : trig_cnt_q + TrigW'(1);
  end

  always_ff @(posedge CLK_26 or negedge RST) begin
    if (!RST) begin
      trig_cnt_q <= '0;
    end else begin
      trig_cnt_q <= trig_cnt_d;
    end
  end

  // Counter keeps running while busy; a pulse landing then is simply lost.
  assign trig = START | (trig_cnt_q == TrigLast);
`else
  assign trig = START;
`endif

  assign sel_ok  = (32'(SS_SEL) < N_SS);
  assign div_end = (div_q == DivLast);

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sel_d      = sel_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    bit_d      = bit_q;
    div_d      = div_q;
    phase_d    = phase_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    lead_edge  = 1'b0;
    trail_edge = 1'b0;

    unique case (state_q)
      StIdle: begin
        sck_d  = MODE[1];
        mosi_d = 1'b0;
        if (trig && sel_ok) begin
          state_d = StSetup;
          cpol_d  = MODE[1];
          cpha_d  = MODE[0];
          sel_d   = SS_SEL;
          tx_d    = TX_DATA;
          rx_d    = '0;
          bit_d   = BitLast;
          div_d   = '0;
          phase_d = 1'b0;
          // CPHA=0 needs the MSB on the wire before the first leading edge.
          mosi_d  = ~MODE[0] & TX_DATA[DATA_W-1];
        end
      end
      StSetup: begin
        sck_d = cpol_q;
        if (div_end) begin
          div_d     = '0;
          state_d   = StShift;
          phase_d   = 1'b0;
          sck_d     = ~cpol_q;
          lead_edge = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShift: begin
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d    = 1'b1;
            sck_d      = cpol_q;
            trail_edge = 1'b1;
          end else if (bit_q == '0) begin
            state_d = StHold;
            mosi_d  = 1'b0;
          end else begin
            bit_d     = bit_q - BitW'(1);
            phase_d   = 1'b0;
            sck_d     = ~cpol_q;
            lead_edge = 1'b1;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StHold: begin
        sck_d = cpol_q;
        if (div_end) begin
          div_d     = '0;
          state_d   = StIdle;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (lead_edge) begin
      if (cpha_q) begin
        mosi_d = tx_q[DATA_W-1];
        tx_d   = tx_q << 1;
      end else begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
      end
    end

    if (trail_edge) begin
      if (cpha_q) begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
      end else if (bit_q != '0) begin
        mosi_d = tx_q[DATA_W-2];
        tx_d   = tx_q << 1;
      end
    end
  end

  always_ff @(posedge CLK_26 or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sel_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sel_q     <= sel_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign BUSY    = (state_q != StIdle);
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign DONE    = done_q;
  assign RX_DATA = rx_data_q;

  always_comb begin
    SS = '1;
    for (int i = 0; i < N_SS; i++) begin
      if (BUSY && (sel_q == SS_W'(i))) begin
        SS[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: loopback and slave-model transfers in all four modes,
// ignored mid-transfer START, out-of-range select and asynchronous reset during a shift.
module tb_spi_master_param;

  localparam int unsigned DataW  = 16;
  localparam int unsigned ClkDiv = 4;
  localparam int unsigned NSs    = 2;
  localparam int unsigned SsW    = 2;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic [SsW-1:0]   ss_sel  = '0;
  logic [1:0]       mode    = '0;
  logic [DataW-1:0] tx_data = '0;
  logic             miso;
  logic             sck;
  logic             mosi;
  logic [NSs-1:0]   ss;
  logic             busy;
  logic             done;
  logic [DataW-1:0] rx_data;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_W  (DataW),
    .CLK_DIV (ClkDiv),
    .N_SS    (NSs),
    .SS_W    (SsW),
    .TRIG_DIV(1000)
  ) dut (
    .CLK_26 (clk),
    .RST    (rst_n),
    .START  (start),
    .SS_SEL (ss_sel),
    .MODE   (mode),
    .TX_DATA(tx_data),
    .MISO   (miso),
    .SCK    (sck),
    .MOSI   (mosi),
    .SS     (ss),
    .BUSY   (busy),
    .DONE   (done),
    .RX_DATA(rx_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Free-running monitors; stimulus reads deltas.
  int   busy_cycles = 0;
  int   sck_rises   = 0;
  int   sck_toggles = 0;
  int   done_pulses = 0;
  logic sck_prev    = 1'b0;

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (done) done_pulses++;
    if (sck !== sck_prev) sck_toggles++;
    if (busy && sck && !sck_prev) sck_rises++;
    sck_prev = sck;
  end

  // Behavioural slave: drives slave_pat, captures MOSI on the mode's sample edge.
  logic [1:0]  cur_mode  = 2'b00;
  logic        loopback  = 1'b1;
  logic [15:0] slave_pat = 16'h3C5A;
  logic [15:0] sl_rx     = '0;
  logic        sl_miso   = 1'b0;
  logic        sl_sel_q  = 1'b0;
  logic        sl_sck_q  = 1'b0;
  int          sl_idx    = 15;

  always @(ss or sck) begin
    if (!sl_sel_q && !(&ss)) begin
      sl_idx  = 15;
      sl_rx   = '0;
      sl_miso = cur_mode[0] ? 1'b0 : slave_pat[15];
    end else if (sl_sel_q && !(&ss) && (sck !== sl_sck_q)) begin
      if (sck !== cur_mode[1]) begin
        if (cur_mode[0]) begin
          if (sl_idx >= 0) sl_miso = slave_pat[sl_idx];
        end else begin
          sl_rx = {sl_rx[14:0], mosi};
        end
      end else begin
        if (cur_mode[0]) begin
          sl_rx = {sl_rx[14:0], mosi};
          sl_idx--;
        end else begin
          sl_idx--;
          if (sl_idx >= 0) sl_miso = slave_pat[sl_idx];
        end
      end
    end
    sl_sel_q = !(&ss);
    sl_sck_q = sck;
  end

  assign miso = loopback ? mosi : sl_miso;

  logic [15:0] exp_rx_q[$];
  logic [15:0] exp_tx_q[$];

  task automatic run_xfer(input logic [1:0] m, input logic [SsW-1:0] sel, input logic [15:0] tx,
                          input logic loop, input logic [15:0] exp_rx, input logic poke);
    int          b0;
    int          r0;
    int          d0;
    bit          seen;
    logic [1:0]  exp_ss;
    logic [15:0] exp_v;
    logic [15:0] exp_t;
    cur_mode = m;
    mode     = m;
    loopback = loop;
    tick();
    tick();
    check_eq("sck_idle_pre", {31'd0, sck}, {31'd0, m[1]});
    exp_rx_q.push_back(exp_rx);
    exp_tx_q.push_back(tx);
    b0      = busy_cycles;
    r0      = sck_rises;
    d0      = done_pulses;
    ss_sel  = sel;
    tx_data = tx;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tx_data = 16'($urandom);
    ss_sel  = ~sel;
    exp_ss  = 2'b11;
    exp_ss[sel[0]] = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    check_eq("ss_active", {30'd0, ss}, {30'd0, exp_ss});
    if (!m[0]) check_eq("mosi_first_bit", {31'd0, mosi}, {31'd0, tx[15]});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (poke && i == 40) begin
        tx_data = 16'hFFFF;
        ss_sel  = sel;
        start   = 1'b1;
      end
      if (poke && i == 42) start = 1'b0;
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    exp_v = exp_rx_q.pop_front();
    exp_t = exp_tx_q.pop_front();
    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("rx_data", {16'd0, rx_data}, {16'd0, exp_v});
      check_eq("busy_low_at_done", {31'd0, busy}, 32'd0);
      check_eq("ss_idle_at_done", {30'd0, ss}, 32'd3);
      check_eq("busy_cycles", busy_cycles - b0, 136);
      check_eq("sck_rises", sck_rises - r0, 16);
      if (!loop) check_eq("slave_rx", {16'd0, sl_rx}, {16'd0, exp_t});
    end
    tick();
    tick();
    tick();
    check_eq("done_pulses", done_pulses - d0, 1);
    check_eq("no_requeue", {31'd0, busy}, 32'd0);
    check_eq("sck_idle_post", {31'd0, sck}, {31'd0, m[1]});
    check_eq("mosi_idle", {31'd0, mosi}, 32'd0);
  endtask

  initial begin
    int b0;
    int t0;
    int d0;
    int r0;

    tick();
    check_eq("rst_sck", {31'd0, sck}, 32'd0);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("rst_ss", {30'd0, ss}, 32'd3);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rx", {16'd0, rx_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_xfer(2'b00, 2'd0, 16'hA5C3, 1'b1, 16'hA5C3, 1'b0);
    run_xfer(2'b01, 2'd1, 16'h1E69, 1'b0, 16'h3C5A, 1'b0);
    run_xfer(2'b10, 2'd0, 16'hC3A5, 1'b0, 16'h3C5A, 1'b0);
    run_xfer(2'b11, 2'd1, 16'h8001, 1'b0, 16'h3C5A, 1'b0);
    run_xfer(2'b00, 2'd0, 16'h1234, 1'b1, 16'h1234, 1'b1);

    // Out-of-range select must be dropped without any bus activity.
    mode     = 2'b00;
    cur_mode = 2'b00;
    tick();
    b0     = busy_cycles;
    t0     = sck_toggles;
    d0     = done_pulses;
    ss_sel = 2'd2;
    start  = 1'b1;
    tick();
    check_eq("badsel_ss", {30'd0, ss}, 32'd3);
    ss_sel = 2'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("badsel_busy", busy_cycles - b0, 0);
    check_eq("badsel_sck", sck_toggles - t0, 0);
    check_eq("badsel_done", done_pulses - d0, 0);
    check_eq("badsel_ss_end", {30'd0, ss}, 32'd3);

    // Reset during bit 5 of the shift.
    mode     = 2'b11;
    cur_mode = 2'b11;
    loopback = 1'b0;
    tick();
    tick();
    d0      = done_pulses;
    r0      = sck_rises;
    ss_sel  = 2'd1;
    tx_data = 16'hBEEF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 87; i++) tick();
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    check_eq("pre_reset_rises", sck_rises - r0, 10);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ss", {30'd0, ss}, 32'd3);
    check_eq("abort_sck", {31'd0, sck}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_rx", {16'd0, rx_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("abort_no_done", done_pulses - d0, 0);

    run_xfer(2'b00, 2'd1, 16'h5AA5, 1'b1, 16'h5AA5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
